led_pattern_gen: RTL and testbench

Multi-channel LED pattern driver for the door-lock front panel; it generalises the single fixed-rate blinker to N independently commanded channels. Each channel can be OFF, solid ON, continuous BLINK, or a finite BURST of k pulses with a completion pulse. It sits between the lock FSM, which issues one command per event, and the LED pins. One shared prescaler provides the time base.

---
 rtl/led_pattern_pkg.sv | 18 +
 rtl/led_channel.sv | 105 ++++++++++
 rtl/led_pattern_gen.sv | 88 ++++++++
 tb/tb_led_pattern_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern driver.
package led_pattern_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // Prescaler divide ratio; callers must choose clk_in >= tick_hz.
    function automatic int tick_div(input int clk_in, input int tick_hz);
        return clk_in / tick_hz;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds the commanded mode, the phase and remaining-pulse
// counters, and the registered led/busy/done outputs.
//
// mode        | meaning
// MODE_OFF    | led dark, no activity
// MODE_ON     | led solid on
// MODE_BLINK  | toggle every `half` ticks, forever
// MODE_BURST  | toggle every `half` ticks until `remain` on-phases are used
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cmd,
    input  mode_t            cmd_mode,
    input  logic [CNT_W-1:0] cmd_half,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    mode_t            mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] remain;

    // Channel FSM: a command always wins over a same-cycle tick and restarts the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= MODE_OFF;
            half   <= '0;
            phase  <= '0;
            remain <= '0;
            led    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd) begin
                half  <= (cmd_half == '0) ? CNT_W'(1) : cmd_half;
                phase <= '0;
                case (cmd_mode)
                    MODE_OFF: begin
                        mode   <= MODE_OFF;
                        led    <= 1'b0;
                        busy   <= 1'b0;
                        remain <= '0;
                    end
                    MODE_ON: begin
                        mode   <= MODE_ON;
                        led    <= 1'b1;
                        busy   <= 1'b0;
                        remain <= '0;
                    end
                    MODE_BLINK: begin
                        mode   <= MODE_BLINK;
                        led    <= 1'b1;
                        busy   <= 1'b0;
                        remain <= '0;
                    end
                    MODE_BURST: begin
                        if (cmd_count == '0) begin
                            // Empty burst completes immediately.
                            mode   <= MODE_OFF;
                            led    <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            remain <= '0;
                        end else begin
                            mode   <= MODE_BURST;
                            led    <= 1'b1;
                            busy   <= 1'b1;
                            remain <= cmd_count;
                        end
                    end
                endcase
            end else if (tick && (mode == MODE_BLINK || mode == MODE_BURST)) begin
                if (phase == half - CNT_W'(1)) begin
                    phase <= '0;
                    if (mode == MODE_BURST && !led) begin
                        // End of an off phase: either the last one, or start the next pulse.
                        if (remain == CNT_W'(1)) begin
                            mode   <= MODE_OFF;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            remain <= '0;
                        end else begin
                            remain <= remain - CNT_W'(1);
                            led    <= 1'b1;
                        end
                    end else begin
                        led <= ~led;
                    end
                end else begin
                    phase <= phase + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: shared tick prescaler, command decode
// and N_CH led_channel instances. Define LED_DIM_EN to add the i_dim port
// and a 16-step PWM brightness gate on every output.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter  int CLK_IN  = 500,
    parameter  int TICK_HZ = 100,
    parameter  int N_CH    = 4,
    parameter  int CNT_W   = CNT_W_DEFAULT,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_cmd_valid,
    input  logic [CH_W-1:0]  i_cmd_ch,
    input  logic [1:0]       i_cmd_mode,
    input  logic [CNT_W-1:0] i_cmd_half,
    input  logic [CNT_W-1:0] i_cmd_count,
`ifdef LED_DIM_EN
    input  logic [3:0]       i_dim,
`endif
    output logic [N_CH-1:0]  o_led,
    output logic [N_CH-1:0]  o_busy,
    output logic [N_CH-1:0]  o_done
);

    localparam int TICK_DIV = tick_div(CLK_IN, TICK_HZ);
    localparam int PSC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PSC_W-1:0] psc_cnt;
    logic             tick;
    logic [N_CH-1:0]  led_state;
    logic [N_CH-1:0]  cmd_hit;

    assign tick = (psc_cnt == PSC_W'(TICK_DIV - 1));

    // Free-running prescaler; commands never disturb it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Channel numbers beyond N_CH-1 match no instance and are dropped.
        assign cmd_hit[g] = i_cmd_valid && (i_cmd_ch == CH_W'(g));

        led_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (i_clk),
            .rst       (i_reset),
            .tick      (tick),
            .cmd       (cmd_hit[g]),
            .cmd_mode  (mode_t'(i_cmd_mode)),
            .cmd_half  (i_cmd_half),
            .cmd_count (i_cmd_count),
            .led       (led_state[g]),
            .busy      (o_busy[g]),
            .done      (o_done[g])
        );
    end

`ifdef LED_DIM_EN
    logic [3:0] pwm_cnt;
    logic       dim_gate;

    // Brightness PWM counter, free-running over 16 steps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Full scale bypasses the PWM so 4'hF is truly solid.
    assign dim_gate = (i_dim == 4'hF) || (pwm_cnt < i_dim);
    assign o_led    = led_state & {N_CH{i_en & dim_gate}};
`else
    assign o_led    = led_state & {N_CH{i_en}};
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboarded directed bench for led_pattern_gen (TICK_DIV = 5).
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    typedef struct {
        int          cyc;
        logic [20:0] exp;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_ch = '0;
    logic [1:0] cmd_mode = '0;
    logic [7:0] cmd_half = '0;
    logic [7:0] cmd_count = '0;
    logic       aux_valid = 1'b0;
    logic [1:0] aux_ch = '0;
    logic [3:0] dim = 4'hF;

    logic [3:0] o_led, o_busy, o_done;
    logic [2:0] a_led, a_busy, a_done;
    logic [20:0] obs;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   base = 0;

    assign obs = {a_done, a_busy, a_led, o_done, o_busy, o_led};

    led_pattern_gen #(.CLK_IN(500), .TICK_HZ(100), .N_CH(4), .CNT_W(8)) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_cmd_valid (cmd_valid),
        .i_cmd_ch    (cmd_ch),
        .i_cmd_mode  (cmd_mode),
        .i_cmd_half  (cmd_half),
        .i_cmd_count (cmd_count),
`ifdef LED_DIM_EN
        .i_dim       (dim),
`endif
        .o_led       (o_led),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Three-channel copy: its 2-bit channel field can address a non-existent channel 3.
    led_pattern_gen #(.CLK_IN(500), .TICK_HZ(100), .N_CH(3), .CNT_W(8)) u_aux (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_en        (en),
        .i_cmd_valid (aux_valid),
        .i_cmd_ch    (aux_ch),
        .i_cmd_mode  (cmd_mode),
        .i_cmd_half  (cmd_half),
        .i_cmd_count (cmd_count),
`ifdef LED_DIM_EN
        .i_dim       (dim),
`endif
        .o_led       (a_led),
        .o_busy      (a_busy),
        .o_done      (a_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_checks = n_checks + 1;
            if (mon_e.cyc < cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: missed its cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (obs !== mon_e.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @%0d: got %h required %h", mon_e.name, cyc - base, obs, mon_e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [20:0] mk(input logic [3:0] l, input logic [3:0] b,
                                       input logic [3:0] d, input logic [2:0] al);
        return {6'b0, al, d, b, l};
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [20:0] e);
        exp_t x;
        x.cyc  = c;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        aux_valid = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic cmd(input logic [1:0] ch, input logic [1:0] m,
                       input logic [7:0] h, input logic [7:0] n);
        cmd_ch = ch; cmd_mode = m; cmd_half = h; cmd_count = n;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic aux_cmd(input logic [1:0] ch, input logic [1:0] m);
        aux_ch = ch; cmd_mode = m; cmd_half = 8'd1; cmd_count = 8'd0;
        aux_valid = 1'b1;
        @(posedge clk);
        #1;
        aux_valid = 1'b0;
    endtask

    initial begin
        // BLINK half=2 on ch1; ticks are sampled at base+5, +10, ...
        do_reset();
        expect_at(base + 1,  "reset_state", '0);
        expect_at(base + 3,  "blink_first_on", mk(4'b0010, 4'b0, 4'b0, 3'b0));
        expect_at(base + 9,  "blink_first_on_end", mk(4'b0010, 4'b0, 4'b0, 3'b0));
        expect_at(base + 10, "blink_off", '0);
        expect_at(base + 19, "blink_off_end", '0);
        expect_at(base + 20, "blink_on2", mk(4'b0010, 4'b0, 4'b0, 3'b0));
        expect_at(base + 30, "blink_off2", '0);
        expect_at(base + 41, "blink_on3", mk(4'b0010, 4'b0, 4'b0, 3'b0));
        expect_at(base + 42, "async_reset", '0);
        goto(base + 2);
        cmd(2'd1, MODE_BLINK, 8'd2, 8'd0);
        goto(base + 42);
        do_reset();
        expect_at(base + 3,  "dark_after_reset", '0);
        expect_at(base + 12, "dark_after_reset2", '0);
        goto(base + 13);

        // BURST half=1 count=3 on ch0
        do_reset();
        expect_at(base + 3,  "burst_p1", mk(4'b0001, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 4,  "burst_p1_end", mk(4'b0001, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 5,  "burst_g1", mk(4'b0000, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 10, "burst_p2", mk(4'b0001, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 14, "burst_p2_end", mk(4'b0001, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 15, "burst_g2", mk(4'b0000, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 20, "burst_p3", mk(4'b0001, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 25, "burst_g3", mk(4'b0000, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 29, "burst_g3_end", mk(4'b0000, 4'b0001, 4'b0, 3'b0));
        expect_at(base + 30, "burst_done", mk(4'b0000, 4'b0000, 4'b0001, 3'b0));
        expect_at(base + 31, "burst_done_once", '0);
        expect_at(base + 40, "burst_no_p4", '0);
        goto(base + 2);
        cmd(2'd0, MODE_BURST, 8'd1, 8'd3);
        goto(base + 41);

        // BURST count=0 on ch2
        do_reset();
        expect_at(base + 3, "burst0_done", mk(4'b0000, 4'b0000, 4'b0100, 3'b0));
        expect_at(base + 4, "burst0_after", '0);
        expect_at(base + 8, "burst0_quiet", '0);
        goto(base + 2);
        cmd(2'd2, MODE_BURST, 8'd1, 8'd0);
        goto(base + 9);

        // BURST count=5 half=0 (acts as 1) on ch3, aborted by OFF after pulse 2
        do_reset();
        expect_at(base + 3,  "abort_p1", mk(4'b1000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 5,  "abort_g1", mk(4'b0000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 10, "abort_p2", mk(4'b1000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 14, "abort_p2_end", mk(4'b1000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 15, "abort_g2", mk(4'b0000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 16, "abort_g2b", mk(4'b0000, 4'b1000, 4'b0, 3'b0));
        expect_at(base + 17, "abort_off", '0);
        expect_at(base + 20, "abort_quiet1", '0);
        expect_at(base + 30, "abort_quiet2", '0);
        expect_at(base + 50, "abort_no_done", '0);
        goto(base + 2);
        cmd(2'd3, MODE_BURST, 8'd0, 8'd5);
        goto(base + 16);
        cmd(2'd3, MODE_OFF, 8'd0, 8'd0);
        goto(base + 51);

        // ON with enable low, enable gating, out-of-range channel on the 3-channel copy
        do_reset();
        expect_at(base + 3,  "en_low_on", '0);
        expect_at(base + 4,  "en_low_on2", '0);
        expect_at(base + 5,  "en_high", mk(4'b0001, 4'b0, 4'b0, 3'b0));
        expect_at(base + 9,  "bad_ch_ignored", mk(4'b0001, 4'b0, 4'b0, 3'b0));
        expect_at(base + 10, "bad_ch_ignored2", mk(4'b0001, 4'b0, 4'b0, 3'b0));
        expect_at(base + 11, "aux_ch0_on", mk(4'b0001, 4'b0, 4'b0, 3'b001));
        expect_at(base + 12, "en_low_all", '0);
        goto(base + 2);
        en = 1'b0;
        cmd(2'd0, MODE_ON, 8'd1, 8'd0);
        goto(base + 5);
        en = 1'b1;
        goto(base + 8);
        aux_cmd(2'd3, MODE_ON);
        goto(base + 10);
        aux_cmd(2'd0, MODE_ON);
        goto(base + 12);
        en = 1'b0;
        goto(base + 15);

        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: never reached cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
